// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, per-opcode execute length,
// and the sequencer state encoding.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Execute cycles after FETCH; the instruction register uses the same table.
  function automatic logic [2:0] exec_cycles(input logic [2:0] opcode);
    case (opcode)
      OP_HLT:                         exec_cycles = 3'd0;
      OP_SKZ, OP_JMP:                 exec_cycles = 3'd3;
      OP_STO:                         exec_cycles = 3'd4;
      default:                        exec_cycles = 3'd5;
    endcase
  endfunction

endpackage

// File: rtl/program_counter.sv
// 5-bit program counter: load has priority over increment/skip; wraps mod 32.
module program_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       skip,
  input  logic       load,
  input  logic [4:0] load_value,
  output logic [4:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= 5'd0;
    else if (load)
      pc <= load_value;
    else if (inc || skip)
      pc <= pc + 5'd1;
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/execute sequencer: drives the instruction byte stream and the
// memory/accumulator strobes, in lockstep with the instruction register.
//
//   state    | meaning
//   ST_FETCH | present mem[pc] to the IR, latch opcode/operand, pc+1
//   ST_EXEC  | count phase_cnt down N..1, issue per-opcode strobes
//   ST_HALT  | feed 8'h00 to the IR until resume
module instruction_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_rdata,
  input  logic       ac_zero,
  input  logic       resume,
  output logic [4:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] ir_data,
  output logic       ac_load,
  output logic [4:0] pc_value,
  output logic       halted,
  output logic [2:0] phase_cnt
);

  state_t     state;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic [2:0] phase_q;
  logic [4:0] pc;
  logic       last_exec;
  logic       alu_op;

  assign last_exec = (state == ST_EXEC) && (phase_q == 3'd1);
  assign alu_op    = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);

  program_counter u_pc (
    .clk        (clk),
    .rst        (rst),
    .inc        (state == ST_FETCH),
    .skip       (last_exec && (opcode == OP_SKZ) && ac_zero),
    .load       (last_exec && (opcode == OP_JMP)),
    .load_value (operand),
    .pc         (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FETCH;
      opcode  <= OP_HLT;
      operand <= 5'd0;
      phase_q <= 3'd0;
    end else begin
      case (state)
        ST_FETCH: begin
          opcode  <= mem_rdata[7:5];
          operand <= mem_rdata[4:0];
          phase_q <= exec_cycles(mem_rdata[7:5]);
          state   <= (mem_rdata[7:5] == OP_HLT) ? ST_HALT : ST_EXEC;
        end
        ST_EXEC: begin
          phase_q <= phase_q - 3'd1;
          if (phase_q <= 3'd1) begin
            phase_q <= 3'd0;
            state   <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (resume)
            state <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Outputs are decoded from state and forced low while reset is held.
  always_comb begin
    mem_addr  = 5'd0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    ir_data   = 8'h00;
    ac_load   = 1'b0;
    halted    = 1'b0;
    pc_value  = 5'd0;
    phase_cnt = 3'd0;
    if (!rst) begin
      pc_value  = pc;
      phase_cnt = phase_q;
      case (state)
        ST_FETCH: begin
          mem_addr = pc;
          mem_rd   = 1'b1;
          ir_data  = mem_rdata;
        end
        ST_EXEC: begin
          mem_addr = ((opcode == OP_SKZ) || (opcode == OP_JMP)) ? pc : operand;
          mem_rd   = alu_op;
          ac_load  = alu_op && (phase_q == 3'd1);
          mem_wr   = (opcode == OP_STO) && (phase_q == 3'd2);
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
